// File: rtl/ic_refill_ctrl.sv
// ic_refill_ctrl: instruction-cache line refill controller with flush abort
module ic_refill_ctrl #(
  parameter int BLOCK_WORDS = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          miss_i,
  input  logic [31:0]                   miss_addr_i,
  input  logic                          flush_i,
  output logic                          mem_req_o,
  output logic [31:0]                   mem_addr_o,
  input  logic                          mem_ack_i,
  input  logic [31:0]                   mem_rdata_i,
  output logic                          fill_we_o,
  output logic [$clog2(BLOCK_WORDS)-1:0] fill_word_o,
  output logic [31:0]                   fill_data_o,
  output logic [31:0]                   fill_line_addr_o,
  output logic                          ic_repl_permit_o,
  output logic                          stall_f_o
);
  localparam int WORD_IDX_W = $clog2(BLOCK_WORDS);
  localparam int OFF = WORD_IDX_W + 2;
  typedef enum logic [1:0] {IDLE, REQ, DRAIN, DONE} state_t;
  state_t r_state, w_next;
  logic [WORD_IDX_W-1:0] r_word_cnt;
  logic [31:0] r_line_base;
  logic w_start, w_ack, w_last;
  assign w_start = (r_state == IDLE) & miss_i & ~flush_i;
  assign mem_req_o = (r_state == REQ) | (r_state == DRAIN);
  assign w_ack = mem_req_o & mem_ack_i;
  assign w_last = r_word_cnt == WORD_IDX_W'(BLOCK_WORDS - 1);
  assign fill_we_o = (r_state == REQ) & w_ack & ~flush_i;
  assign fill_word_o = r_word_cnt;
  assign fill_data_o = mem_rdata_i;
  assign fill_line_addr_o = r_line_base;
  assign mem_addr_o = {r_line_base[31:OFF], r_word_cnt, 2'b00};
  assign ic_repl_permit_o = r_state == DONE;
  // reset gating keeps stall low while reset is held even if a miss is still presented
  assign stall_f_o = ~reset & ((r_state != IDLE) | w_start);
  // state, word counter and captured line base
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_word_cnt <= '0;
      r_line_base <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_word_cnt <= '0;
        r_line_base <= {miss_addr_i[31:OFF], {OFF{1'b0}}};
      end else if (fill_we_o) begin
        r_word_cnt <= r_word_cnt + 1'b1;
      end
    end
  end
  // next-state: an outstanding request must drain before returning to idle
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  w_next = w_start ? REQ : IDLE;
      REQ:   w_next = flush_i ? (w_ack ? IDLE : DRAIN) : (w_ack & w_last ? DONE : REQ);
      DRAIN: w_next = w_ack ? IDLE : DRAIN;
      DONE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_ic_refill_ctrl.sv
// tb_ic_refill_ctrl: directed self-checking bench for the I-cache refill controller
module tb_ic_refill_ctrl;
  logic clk = 1'b0;
  logic reset, miss_i, flush_i, mem_ack_i;
  logic [31:0] miss_addr_i, mem_rdata_i;
  logic mem_req_o, fill_we_o, ic_repl_permit_o, stall_f_o;
  logic [31:0] mem_addr_o, fill_data_o, fill_line_addr_o;
  logic [1:0] fill_word_o;
  int n_cmp = 0;
  int n_bad = 0;

  ic_refill_ctrl #(.BLOCK_WORDS(4)) dut (
    .clk(clk), .reset(reset), .miss_i(miss_i), .miss_addr_i(miss_addr_i),
    .flush_i(flush_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .fill_we_o(fill_we_o),
    .fill_word_o(fill_word_o), .fill_data_o(fill_data_o),
    .fill_line_addr_o(fill_line_addr_o), .ic_repl_permit_o(ic_repl_permit_o),
    .stall_f_o(stall_f_o)
  );

  always #5 clk = ~clk;

  task tick;
    @(posedge clk);
    #1;
  endtask

  task test_reset;
    reset = 1'b1; miss_i = 1'b0; flush_i = 1'b0; mem_ack_i = 1'b0;
    miss_addr_i = '0; mem_rdata_i = '0;
    #3;
    n_cmp++; if (mem_req_o !== 1'b0) begin n_bad++; $display("FAIL rst_req got %b want 0", mem_req_o); end
    n_cmp++; if (mem_addr_o !== 32'h0) begin n_bad++; $display("FAIL rst_addr got %h want 0", mem_addr_o); end
    n_cmp++; if (fill_we_o !== 1'b0) begin n_bad++; $display("FAIL rst_we got %b want 0", fill_we_o); end
    n_cmp++; if (ic_repl_permit_o !== 1'b0) begin n_bad++; $display("FAIL rst_permit got %b want 0", ic_repl_permit_o); end
    n_cmp++; if (stall_f_o !== 1'b0) begin n_bad++; $display("FAIL rst_stall got %b want 0", stall_f_o); end
    n_cmp++; if (fill_line_addr_o !== 32'h0) begin n_bad++; $display("FAIL rst_line got %h want 0", fill_line_addr_o); end
    tick;
    reset = 1'b0;
  endtask

  task test_refill_fast;
    tick;
    miss_i = 1'b1; miss_addr_i = 32'h0000_1234; #3;
    n_cmp++; if (stall_f_o !== 1'b1) begin n_bad++; $display("FAIL fast_miss_stall got %b want 1", stall_f_o); end
    n_cmp++; if (mem_req_o !== 1'b0) begin n_bad++; $display("FAIL fast_miss_req got %b want 0", mem_req_o); end
    for (int w = 0; w < 4; w++) begin
      tick;
      mem_ack_i = 1'b1; mem_rdata_i = 32'hA5A5_0000 + w; #3;
      n_cmp++; if (mem_req_o !== 1'b1) begin n_bad++; $display("FAIL fast_req%0d got %b want 1", w, mem_req_o); end
      n_cmp++; if (mem_addr_o !== 32'h1230 + 4 * w) begin n_bad++; $display("FAIL fast_addr%0d got %h want %h", w, mem_addr_o, 32'h1230 + 4 * w); end
      n_cmp++; if (fill_we_o !== 1'b1) begin n_bad++; $display("FAIL fast_we%0d got %b want 1", w, fill_we_o); end
      n_cmp++; if (fill_word_o !== 2'(w)) begin n_bad++; $display("FAIL fast_word%0d got %0d want %0d", w, fill_word_o, w); end
      n_cmp++; if (fill_data_o !== 32'hA5A5_0000 + w) begin n_bad++; $display("FAIL fast_data%0d got %h want %h", w, fill_data_o, 32'hA5A5_0000 + w); end
      n_cmp++; if (fill_line_addr_o !== 32'h1230) begin n_bad++; $display("FAIL fast_line%0d got %h want 1230", w, fill_line_addr_o); end
      n_cmp++; if (stall_f_o !== 1'b1) begin n_bad++; $display("FAIL fast_stall%0d got %b want 1", w, stall_f_o); end
    end
    tick;
    mem_ack_i = 1'b0; #3;
    n_cmp++; if (ic_repl_permit_o !== 1'b1) begin n_bad++; $display("FAIL fast_permit got %b want 1", ic_repl_permit_o); end
    n_cmp++; if (mem_req_o !== 1'b0) begin n_bad++; $display("FAIL fast_done_req got %b want 0", mem_req_o); end
    n_cmp++; if (stall_f_o !== 1'b1) begin n_bad++; $display("FAIL fast_done_stall got %b want 1", stall_f_o); end
    tick;
    miss_i = 1'b0; #3;
    n_cmp++; if (ic_repl_permit_o !== 1'b0) begin n_bad++; $display("FAIL fast_permit_end got %b want 0", ic_repl_permit_o); end
    n_cmp++; if (stall_f_o !== 1'b0) begin n_bad++; $display("FAIL fast_stall_end got %b want 0", stall_f_o); end
  endtask

  task test_refill_slow;
    int n_we, n_perm;
    n_we = 0; n_perm = 0;
    tick;
    miss_i = 1'b1; miss_addr_i = 32'h0000_1234; #3;
    for (int w = 0; w < 4; w++) begin
      for (int d = 0; d < 4; d++) begin
        tick;
        mem_ack_i = (d == 3); mem_rdata_i = 32'h5000_0000 + w; #3;
        n_cmp++; if (mem_addr_o !== 32'h1230 + 4 * w) begin n_bad++; $display("FAIL slow_addr%0d_%0d got %h want %h", w, d, mem_addr_o, 32'h1230 + 4 * w); end
        if (fill_we_o) n_we++;
        if (ic_repl_permit_o) n_perm++;
      end
    end
    tick;
    mem_ack_i = 1'b0; #3;
    if (ic_repl_permit_o) n_perm++;
    tick;
    miss_i = 1'b0; #3;
    if (ic_repl_permit_o) n_perm++;
    n_cmp++; if (n_we !== 4) begin n_bad++; $display("FAIL slow_we_count got %0d want 4", n_we); end
    n_cmp++; if (n_perm !== 1) begin n_bad++; $display("FAIL slow_permit_count got %0d want 1", n_perm); end
    n_cmp++; if (stall_f_o !== 1'b0) begin n_bad++; $display("FAIL slow_stall_end got %b want 0", stall_f_o); end
  endtask

  task test_flush_drain;
    tick;
    miss_i = 1'b1; miss_addr_i = 32'h0000_1234; #3;
    for (int w = 0; w < 2; w++) begin
      tick;
      mem_ack_i = 1'b1; mem_rdata_i = 32'h6000_0000 + w; #3;
    end
    tick;
    mem_ack_i = 1'b0; flush_i = 1'b1; #3;
    n_cmp++; if (mem_addr_o !== 32'h1238) begin n_bad++; $display("FAIL drain_flush_addr got %h want 1238", mem_addr_o); end
    n_cmp++; if (fill_we_o !== 1'b0) begin n_bad++; $display("FAIL drain_flush_we got %b want 0", fill_we_o); end
    tick;
    flush_i = 1'b0; miss_i = 1'b0; #3;
    n_cmp++; if (mem_req_o !== 1'b1) begin n_bad++; $display("FAIL drain_req got %b want 1", mem_req_o); end
    n_cmp++; if (mem_addr_o !== 32'h1238) begin n_bad++; $display("FAIL drain_addr got %h want 1238", mem_addr_o); end
    n_cmp++; if (stall_f_o !== 1'b1) begin n_bad++; $display("FAIL drain_stall got %b want 1", stall_f_o); end
    tick;
    mem_ack_i = 1'b1; #3;
    n_cmp++; if (fill_we_o !== 1'b0) begin n_bad++; $display("FAIL drain_ack_we got %b want 0", fill_we_o); end
    n_cmp++; if (ic_repl_permit_o !== 1'b0) begin n_bad++; $display("FAIL drain_ack_permit got %b want 0", ic_repl_permit_o); end
    tick;
    mem_ack_i = 1'b0; #3;
    n_cmp++; if (stall_f_o !== 1'b0) begin n_bad++; $display("FAIL drain_end_stall got %b want 0", stall_f_o); end
    n_cmp++; if (mem_req_o !== 1'b0) begin n_bad++; $display("FAIL drain_end_req got %b want 0", mem_req_o); end
    n_cmp++; if (ic_repl_permit_o !== 1'b0) begin n_bad++; $display("FAIL drain_end_permit got %b want 0", ic_repl_permit_o); end
  endtask

  task test_flush_last;
    tick;
    miss_i = 1'b1; miss_addr_i = 32'h0000_1234; #3;
    for (int w = 0; w < 3; w++) begin
      tick;
      mem_ack_i = 1'b1; mem_rdata_i = 32'h7000_0000 + w; #3;
    end
    tick;
    flush_i = 1'b1; #3;
    n_cmp++; if (mem_addr_o !== 32'h123C) begin n_bad++; $display("FAIL last_addr got %h want 123c", mem_addr_o); end
    n_cmp++; if (fill_we_o !== 1'b0) begin n_bad++; $display("FAIL last_we got %b want 0", fill_we_o); end
    tick;
    flush_i = 1'b0; miss_i = 1'b0; mem_ack_i = 1'b0; #3;
    n_cmp++; if (ic_repl_permit_o !== 1'b0) begin n_bad++; $display("FAIL last_permit got %b want 0", ic_repl_permit_o); end
    n_cmp++; if (mem_req_o !== 1'b0) begin n_bad++; $display("FAIL last_req got %b want 0", mem_req_o); end
    n_cmp++; if (stall_f_o !== 1'b0) begin n_bad++; $display("FAIL last_stall got %b want 0", stall_f_o); end
  endtask

  task test_reset_mid;
    tick;
    miss_i = 1'b1; miss_addr_i = 32'h0000_1234; #3;
    tick;
    mem_ack_i = 1'b1; mem_rdata_i = 32'h8000_0000; #3;
    tick;
    mem_ack_i = 1'b0; mem_rdata_i = 32'h0; #1;
    reset = 1'b1; #2;
    n_cmp++; if (mem_req_o !== 1'b0) begin n_bad++; $display("FAIL rmid_req got %b want 0", mem_req_o); end
    n_cmp++; if (mem_addr_o !== 32'h0) begin n_bad++; $display("FAIL rmid_addr got %h want 0", mem_addr_o); end
    n_cmp++; if (fill_word_o !== 2'd0) begin n_bad++; $display("FAIL rmid_word got %0d want 0", fill_word_o); end
    n_cmp++; if (fill_line_addr_o !== 32'h0) begin n_bad++; $display("FAIL rmid_line got %h want 0", fill_line_addr_o); end
    n_cmp++; if (stall_f_o !== 1'b0) begin n_bad++; $display("FAIL rmid_stall got %b want 0", stall_f_o); end
    tick;
    reset = 1'b0; miss_addr_i = 32'h0000_2008; #3;
    n_cmp++; if (stall_f_o !== 1'b1) begin n_bad++; $display("FAIL rmid_miss_stall got %b want 1", stall_f_o); end
    for (int w = 0; w < 4; w++) begin
      tick;
      mem_ack_i = 1'b1; mem_rdata_i = 32'h9000_0000 + w; #3;
      n_cmp++; if (mem_addr_o !== 32'h2000 + 4 * w) begin n_bad++; $display("FAIL rmid_addr%0d got %h want %h", w, mem_addr_o, 32'h2000 + 4 * w); end
      n_cmp++; if (fill_word_o !== 2'(w)) begin n_bad++; $display("FAIL rmid_word%0d got %0d want %0d", w, fill_word_o, w); end
    end
    n_cmp++; if (fill_line_addr_o !== 32'h2000) begin n_bad++; $display("FAIL rmid_line2 got %h want 2000", fill_line_addr_o); end
    tick;
    mem_ack_i = 1'b0; #3;
    n_cmp++; if (ic_repl_permit_o !== 1'b1) begin n_bad++; $display("FAIL rmid_permit got %b want 1", ic_repl_permit_o); end
    tick;
    miss_i = 1'b0; #3;
  endtask

  task test_idle_ignore;
    tick;
    miss_i = 1'b1; flush_i = 1'b1; miss_addr_i = 32'h0000_3000; #3;
    n_cmp++; if (stall_f_o !== 1'b0) begin n_bad++; $display("FAIL idle_flush_stall got %b want 0", stall_f_o); end
    tick;
    miss_i = 1'b0; flush_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF; #3;
    n_cmp++; if (mem_req_o !== 1'b0) begin n_bad++; $display("FAIL idle_req got %b want 0", mem_req_o); end
    n_cmp++; if (fill_we_o !== 1'b0) begin n_bad++; $display("FAIL idle_spur_we got %b want 0", fill_we_o); end
    tick;
    mem_ack_i = 1'b0; #3;
    n_cmp++; if (mem_req_o !== 1'b0) begin n_bad++; $display("FAIL idle_after_req got %b want 0", mem_req_o); end
    n_cmp++; if (stall_f_o !== 1'b0) begin n_bad++; $display("FAIL idle_after_stall got %b want 0", stall_f_o); end
    n_cmp++; if (ic_repl_permit_o !== 1'b0) begin n_bad++; $display("FAIL idle_after_permit got %b want 0", ic_repl_permit_o); end
  endtask

  initial begin
    test_reset;
    test_refill_fast;
    test_refill_slow;
    test_flush_drain;
    test_flush_last;
    test_reset_mid;
    test_idle_ignore;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
